grid_scan_driver: RTL and testbench

Display-side consumer of the 16-bit game grid (bits [7:0] = row 0, bits [15:8] = row 1, bit index within a row = column). The block accepts grid frames through a load/ack handshake and double-buffers them so frames swap only at frame boundaries, with no tearing. It time-multiplexes the two rows onto a physical 2x8 LED matrix, with inter-row blanking and PWM brightness. It also decodes the single lit pixel back to a (column, row) position for status and debug.

---
 rtl/grid_scan_pkg.sv | 21 ++
 rtl/grid_pos_decoder.sv | 44 ++++
 rtl/grid_scan_driver.sv | 139 +++++++++++++
 tb/tb_grid_scan_driver.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/grid_scan_pkg.sv
// ============================================================================
// grid_scan_pkg: shared scan-state encoding and grid geometry. Rev 1.0
// ============================================================================
`default_nettype none

package grid_scan_pkg;

  localparam int GRID_W    = 16;
  localparam int GRID_COLS = 8;
  localparam int GRID_ROWS = 2;

  typedef enum logic [1:0] {
    BLANK0 = 2'd0,
    ROW0   = 2'd1,
    BLANK1 = 2'd2,
    ROW1   = 2'd3
  } scan_state_t;

endpackage

`default_nettype wire

// File: rtl/grid_pos_decoder.sv
// ============================================================================
// grid_pos_decoder: registered (col,row) of the single lit pixel of a grid. Rev 1.0
// ============================================================================
`default_nettype none

module grid_pos_decoder
  import grid_scan_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [GRID_W-1:0] grid,
  output logic              pos_valid,
  output logic [2:0]        pos_col,
  output logic              pos_row
);

  logic       w_one_hot;
  logic [3:0] w_idx;

  // Index of the highest set bit; only meaningful when exactly one bit is set.
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < GRID_W; i++) begin
      if (grid[i]) w_idx = 4'(i);
    end
  end

  assign w_one_hot = (grid != '0) && ((grid & (grid - GRID_W'(1))) == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_valid <= 1'b0;
      pos_col   <= '0;
      pos_row   <= 1'b0;
    end else begin
      pos_valid <= w_one_hot;
      pos_col   <= w_one_hot ? w_idx[2:0] : 3'd0;
      pos_row   <= w_one_hot ? w_idx[3]   : 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/grid_scan_driver.sv
// ============================================================================
// grid_scan_driver: double-buffered 2x8 LED row scan with blanking and PWM;
// optional pixel position decode under GRID_SCAN_POS_DECODE_EN. Rev 1.0
// ============================================================================
`default_nettype none

module grid_scan_driver
  import grid_scan_pkg::*;
#(
  parameter int ROW_LOG2     = 10,
  parameter int BLANK_CYCLES = 16,
  parameter int BRIGHT_W     = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [GRID_W-1:0]    grid_in,
  input  logic                 load,
  output logic                 load_ack,
  input  logic [BRIGHT_W-1:0]  brightness,
  output logic [GRID_ROWS-1:0] row_en,
  output logic [GRID_COLS-1:0] col_out,
  output logic                 frame_done,
  output logic                 pos_valid,
  output logic [2:0]           pos_col,
  output logic                 pos_row
);

  localparam int BLANK_W = $clog2(BLANK_CYCLES + 1);
  localparam int DWELL_W = (ROW_LOG2 > BLANK_W) ? ROW_LOG2 : BLANK_W;
  localparam logic [DWELL_W-1:0] BLANK_LAST = DWELL_W'(BLANK_CYCLES - 1);
  localparam logic [DWELL_W-1:0] ROW_LAST   = DWELL_W'((1 << ROW_LOG2) - 1);

  scan_state_t          r_state;
  scan_state_t          w_next;
  logic [DWELL_W-1:0]   r_dwell;
  logic                 w_last;
  logic [GRID_W-1:0]    r_disp;
  logic [GRID_W-1:0]    r_shadow;
  logic                 r_pending;
  logic                 r_wrap_d;
  logic                 r_swap_d;
  logic                 w_wrap;
  logic                 w_pwm_on;
  logic [GRID_ROWS-1:0] w_row_en;
  logic [GRID_COLS-1:0] w_col;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= BLANK0;
      r_dwell <= '0;
    end else begin
      r_state <= w_next;
      r_dwell <= w_last ? '0 : r_dwell + 1'b1;
    end
  end

  always_comb begin
    w_last = 1'b0;
    case (r_state)
      BLANK0, BLANK1: w_last = (r_dwell == BLANK_LAST);
      default:        w_last = (r_dwell == ROW_LAST);
    endcase
    w_next = r_state;
    if (w_last) begin
      case (r_state)
        BLANK0:  w_next = ROW0;
        ROW0:    w_next = BLANK1;
        BLANK1:  w_next = ROW1;
        default: w_next = BLANK0;
      endcase
    end
  end

  // PWM compares the top BRIGHT_W dwell bits, so each level adds an equal slice.
  always_comb begin
    w_row_en = '0;
    w_col    = '0;
    w_pwm_on = (r_dwell[ROW_LOG2-1 -: BRIGHT_W] <= brightness);
    w_wrap   = (r_state == ROW1) && w_last;
    case (r_state)
      ROW0: begin
        w_row_en = 2'b01;
        if (w_pwm_on) w_col = r_disp[GRID_COLS-1:0];
      end
      ROW1: begin
        w_row_en = 2'b10;
        if (w_pwm_on) w_col = r_disp[GRID_W-1 -: GRID_COLS];
      end
      default: ;
    endcase
  end

  // A load on the swap edge refills the shadow and keeps pending for the next frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_disp     <= '0;
      r_shadow   <= '0;
      r_pending  <= 1'b0;
      r_wrap_d   <= 1'b0;
      r_swap_d   <= 1'b0;
      row_en     <= '0;
      col_out    <= '0;
      frame_done <= 1'b0;
      load_ack   <= 1'b0;
    end else begin
      if (load) begin
        r_shadow  <= grid_in;
        r_pending <= 1'b1;
      end else if (w_wrap) begin
        r_pending <= 1'b0;
      end
      if (w_wrap && r_pending) r_disp <= r_shadow;
      r_wrap_d   <= w_wrap;
      r_swap_d   <= w_wrap && r_pending;
      row_en     <= w_row_en;
      col_out    <= w_col;
      frame_done <= r_wrap_d;
      load_ack   <= r_swap_d;
    end
  end

`ifdef GRID_SCAN_POS_DECODE_EN
  grid_pos_decoder u_pos_decoder (
    .clk       (clk),
    .reset     (reset),
    .grid      (r_disp),
    .pos_valid (pos_valid),
    .pos_col   (pos_col),
    .pos_row   (pos_row)
  );
`else
  assign pos_valid = 1'b0;
  assign pos_col   = 3'd0;
  assign pos_row   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_grid_scan_driver.sv
// ============================================================================
// tb_grid_scan_driver: scoreboard bench for grid_scan_driver (4/2/2 config). Rev 1.0
// ============================================================================
`default_nettype none

module tb_grid_scan_driver;

  localparam int FP = 36;

`ifdef GRID_SCAN_POS_DECODE_EN
  localparam bit POS_EN = 1'b1;
`else
  localparam bit POS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] grid_in = '0;
  logic        load = 1'b0;
  logic [1:0]  brightness = 2'd3;
  logic        load_ack;
  logic [1:0]  row_en;
  logic [7:0]  col_out;
  logic        frame_done;
  logic        pos_valid;
  logic [2:0]  pos_col;
  logic        pos_row;

  grid_scan_driver #(
    .ROW_LOG2     (4),
    .BLANK_CYCLES (2),
    .BRIGHT_W     (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .grid_in    (grid_in),
    .load       (load),
    .load_ack   (load_ack),
    .brightness (brightness),
    .row_en     (row_en),
    .col_out    (col_out),
    .frame_done (frame_done),
    .pos_valid  (pos_valid),
    .pos_col    (pos_col),
    .pos_row    (pos_row)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] frame;
    logic        pv;
    logic [2:0]  pc;
    logic        pr;
  } ack_t;

  ack_t        exp_q[$];
  ack_t        popped;
  int          errors = 0;
  int          checks = 0;
  int          c;
  int          ack_cnt = 0;
  logic [15:0] exp_disp;
  logic [1:0]  br_d;
  logic        exp_pv;
  logic [2:0]  exp_pc;
  logic        exp_pr;

  // Posedges since reset release; state cycle c-1 drives the outputs seen at count c.
  always @(posedge clk or posedge reset) begin
    if (reset) c <= 0;
    else       c <= c + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at count %0d: got %0h, expected %0h", name, c, act, exp);
    end
  endtask

  function automatic logic [1:0] exp_row(input int cnt);
    int p;
    if (cnt == 0) return 2'b00;
    p = (cnt - 1) % FP;
    if (p >= 2 && p < 18) return 2'b01;
    if (p >= 20) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [7:0] exp_col(input int cnt, input logic [15:0] d, input logic [1:0] br);
    int p;
    if (cnt == 0) return 8'h00;
    p = (cnt - 1) % FP;
    if (p >= 2 && p < 18) return (((p - 2) >> 2) <= int'(br)) ? d[7:0] : 8'h00;
    if (p >= 20) return (((p - 20) >> 2) <= int'(br)) ? d[15:8] : 8'h00;
    return 8'h00;
  endfunction

  task automatic push(input logic [15:0] f, input logic pv, input logic [2:0] pc, input logic pr);
    ack_t e;
    e.frame = f;
    e.pv    = pv & POS_EN;
    e.pc    = POS_EN ? pc : 3'd0;
    e.pr    = pr & POS_EN;
    exp_q.push_back(e);
  endtask

  // Monitor: pops an expected frame on every load_ack, then checks each cycle.
  initial begin
    exp_disp = '0;
    br_d     = '0;
    exp_pv   = 1'b0;
    exp_pc   = '0;
    exp_pr   = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_disp = '0;
        exp_pv   = 1'b0;
        exp_pc   = '0;
        exp_pr   = 1'b0;
        br_d     = brightness;
      end else begin
        if (load_ack) begin
          ack_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack at count %0d: got load_ack=1, expected 0", c);
          end else begin
            popped   = exp_q.pop_front();
            exp_disp = popped.frame;
            exp_pv   = popped.pv;
            exp_pc   = popped.pc;
            exp_pr   = popped.pr;
            check("ack_with_frame_done", frame_done, 1);
          end
        end
        check("row_en", row_en, exp_row(c));
        check("col_out", col_out, exp_col(c, exp_disp, br_d));
        check("frame_done", frame_done, (c > FP && c % FP == 1) ? 1 : 0);
        check("pos_valid", pos_valid, exp_pv);
        check("pos_col", pos_col, exp_pc);
        check("pos_row", pos_row, exp_pr);
        br_d = brightness;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(input int p);
    int n = 0;
    while (c % FP != p) begin
      step();
      n++;
      if (n > FP + 4) begin
        checks++;
        errors++;
        $display("FAIL go_to_timeout: got position %0d, expected %0d", c % FP, p);
        break;
      end
    end
  endtask

  task automatic load_frame(input logic [15:0] f);
    grid_in = f;
    load    = 1'b1;
    step();
    load    = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_row_en", row_en, 0);
    check("rst_col_out", col_out, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_load_ack", load_ack, 0);
    check("rst_pos_valid", pos_valid, 0);
    check("rst_pos_col", pos_col, 0);
    check("rst_pos_row", pos_row, 0);
    reset = 1'b0;

    repeat (2 * FP) step();

    // Single pixel in row 0, full brightness.
    go_to(10);
    push(16'h0008, 1'b1, 3'd3, 1'b0);
    load_frame(16'h0008);
    repeat (2 * FP) step();

    // Two loads in one frame: only the last is displayed and acked.
    go_to(5);
    load_frame(16'h0001);
    go_to(20);
    push(16'h0200, 1'b1, 3'd1, 1'b1);
    load_frame(16'h0200);
    repeat (2 * FP) step();
    check("ack_count_mid", ack_cnt, 2);

    // PWM duty at brightness 0 then 2.
    brightness = 2'd0;
    go_to(10);
    push(16'h00FF, 1'b0, 3'd0, 1'b0);
    load_frame(16'h00FF);
    repeat (2 * FP) step();
    brightness = 2'd2;
    repeat (FP) step();
    brightness = 2'd3;

    // Load coinciding with the swap edge.
    go_to(10);
    push(16'h0004, 1'b1, 3'd2, 1'b0);
    load_frame(16'h0004);
    go_to(35);
    push(16'h0100, 1'b1, 3'd0, 1'b1);
    load_frame(16'h0100);
    repeat (2 * FP + 10) step();

    // Asynchronous reset in the middle of row 1.
    go_to(10);
    push(16'h8000, 1'b1, 3'd7, 1'b1);
    load_frame(16'h8000);
    go_to(0);
    step();
    go_to(25);
    check("pre_rst_row_en", row_en, 2'b10);
    check("pre_rst_col_out", col_out, 8'h80);
    check("pre_rst_queue_empty", exp_q.size(), 0);
    #2;
    reset = 1'b1;
    #1;
    check("async_row_en", row_en, 0);
    check("async_col_out", col_out, 0);
    check("async_pos_valid", pos_valid, 0);
    check("async_load_ack", load_ack, 0);
    check("async_frame_done", frame_done, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2 * FP + 4) step();

    check("final_queue_empty", exp_q.size(), 0);
    check("final_ack_count", ack_cnt, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
